// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax normaliser: exp word layout, FSM states, fixed-point decode.
// Combinational only; no latency or backpressure of its own.
package softmax_pkg;

    localparam int EXP_W  = 21;
    localparam int POS_W  = 5;
    localparam int MANT_W = 16;
    localparam int FX_W   = 32;
    localparam int PROB_W = 16;

    localparam logic [POS_W-1:0] POS_MAX = 5'd16;

    typedef struct packed {
        logic [POS_W-1:0]  pos;
        logic [MANT_W-1:0] mant;
    } exp_word_t;

    typedef enum logic [1:0] {
        LOAD,
        DIV,
        EMIT
    } norm_state_e;

    function automatic logic pos_clamped(exp_word_t w);
        return w.pos > POS_MAX;
    endfunction

    // Q16.16 value: mant scaled by 2^(pos-16), with pos saturated at 16.
    function automatic logic [FX_W-1:0] exp_to_fx(exp_word_t w);
        logic [POS_W-1:0] p;
        p = pos_clamped(w) ? POS_MAX : w.pos;
        return {{(FX_W-MANT_W){1'b0}}, w.mant} << p;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider producing ITER quotient bits MSB first; assumes dividend <= divisor (or divisor == 0).
// Latency: start cycle plus ITER-1 cycles, done is a one-cycle pulse after the final bit.
// No backpressure: start must only be pulsed while idle; quotient holds until the next start.
module seq_divider #(
    parameter int DVD_W = 32,
    parameter int DSR_W = 35,
    parameter int ITER  = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DSR_W-1:0] divisor,
    output logic             done,
    output logic [ITER-1:0]  quotient
);

    localparam int CW = $clog2(ITER);

    logic [CW-1:0]    cnt;
    logic             active;
    logic             zero;
    logic [DSR_W:0]   rem;
    logic [DSR_W:0]   cur_rem;
    logic [DSR_W:0]   sub_rem;
    logic [DSR_W-1:0] dsr;
    logic [DSR_W-1:0] cur_dsr;
    logic             ge;
    logic [ITER-1:0]  quo;

    // The start cycle already performs the first (integer) quotient bit.
    always_comb begin
        cur_rem = start ? (DSR_W+1)'(dividend) : rem;
        cur_dsr = start ? divisor : dsr;
        ge      = cur_rem >= {1'b0, cur_dsr};
        sub_rem = ge ? (cur_rem - {1'b0, cur_dsr}) : cur_rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
            zero   <= 1'b0;
            rem    <= '0;
            dsr    <= '0;
            quo    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                active <= 1'b1;
                cnt    <= CW'(1);
                rem    <= sub_rem << 1;
                dsr    <= divisor;
                zero   <= (divisor == '0);
                quo    <= ITER'(ge);
            end else if (active) begin
                rem <= sub_rem << 1;
                quo <= {quo[ITER-2:0], ge};
                cnt <= cnt + CW'(1);
                if (cnt == CW'(ITER-1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    // A zero sum means every element was zero; report 0 rather than the all-ones restoring result.
    assign quotient = zero ? '0 : quo;

endmodule

// File: rtl/softmax_norm.sv
// Softmax normaliser: buffers one vector of exp words, sums them, emits each element / sum as Q0.16 (SOFTMAX_NORM_ROUND_EN: rounded divide).
// Latency: next out_valid 18 cycles after the last input or a non-last output handshake (19 with rounding).
// Backpressure: in_ready only in LOAD; out_data/out_last held stable until out_ready.
module softmax_norm
    import softmax_pkg::*;
#(
    parameter int N_MAX = 8,
    parameter int CNT_W = $clog2(N_MAX),
    parameter int ACC_W = 32 + $clog2(N_MAX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROB_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err
);

`ifdef SOFTMAX_NORM_ROUND_EN
    localparam int DIV_ITER = 18;
`else
    localparam int DIV_ITER = 17;
`endif

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_MAX-1);

    norm_state_e         state;
    norm_state_e         state_nxt;
    logic [FX_W-1:0]     fx_buf [N_MAX];
    logic [ACC_W-1:0]    sum;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    idx;
    logic [CNT_W-1:0]    last_idx;
    exp_word_t           in_word;
    logic [FX_W-1:0]     in_fx;
    logic                in_clamp;
    logic                in_fire;
    logic                load_end;
    logic                out_fire;
    logic                emit_last;
    logic                div_start;
    logic                div_done;
    logic [DIV_ITER-1:0] div_q;
    logic [PROB_W-1:0]   prob;

    assign in_word   = in_data;
    assign in_fx     = exp_to_fx(in_word);
    assign in_clamp  = pos_clamped(in_word);

    assign in_ready  = (state == LOAD);
    assign in_fire   = in_valid && in_ready;
    assign load_end  = in_fire && (in_last || (count == LAST_SLOT));

    assign out_valid = (state == EMIT);
    assign emit_last = (idx == last_idx);
    assign out_last  = out_valid && emit_last;
    assign out_fire  = out_valid && out_ready;
    assign busy      = (state != LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: if (load_end) state_nxt = DIV;
            DIV:  if (div_done) state_nxt = EMIT;
            EMIT: if (out_fire) state_nxt = emit_last ? LOAD : DIV;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            fx_buf[count] <= in_fx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            idx       <= '0;
            last_idx  <= '0;
            sum       <= '0;
            err       <= 1'b0;
            out_data  <= '0;
            div_start <= 1'b0;
        end else begin
            div_start <= 1'b0;
            if (in_fire) begin
                // First element of a vector restarts both the sum and the error flag.
                if (count == '0) begin
                    sum <= ACC_W'(in_fx);
                    err <= in_clamp;
                end else begin
                    sum <= sum + ACC_W'(in_fx);
                    err <= err | in_clamp;
                end
                if (load_end) begin
                    count     <= '0;
                    last_idx  <= count;
                    idx       <= '0;
                    div_start <= 1'b1;
                    if (!in_last) begin
                        err <= 1'b1;
                    end
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
            if (div_done) begin
                out_data <= prob;
            end
            if (out_fire && !emit_last) begin
                idx       <= idx + CNT_W'(1);
                div_start <= 1'b1;
            end
        end
    end

    seq_divider #(
        .DVD_W (FX_W),
        .DSR_W (ACC_W),
        .ITER  (DIV_ITER)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (fx_buf[idx]),
        .divisor  (sum),
        .done     (div_done),
        .quotient (div_q)
    );

`ifdef SOFTMAX_NORM_ROUND_EN
    logic [DIV_ITER:0] rnd;

    // 17 fractional bits rounded half-up to 16, then clipped to just below 1.0.
    always_comb begin
        rnd  = ({1'b0, div_q} + (DIV_ITER+1)'(1)) >> 1;
        prob = (rnd[DIV_ITER:PROB_W] != '0) ? '1 : rnd[PROB_W-1:0];
    end
`else
    assign prob = div_q[PROB_W] ? '1 : div_q[PROB_W-1:0];
`endif

endmodule
